fifo_wr_arbiter: RTL

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers. A granted producer owns the write port for a burst of up to BURST_LEN accepted words. The arbiter gates writes on fifo_full, so the FIFO overflow flag is never raised. It sits directly in front of the FIFO's wr_en/wdata/full pins; the read side of the FIFO is untouched.

---
 rtl/fifo_wr_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant lasts up to BURST_LEN accepted words; writes are gated on fifo_full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int IDX_W     = $clog2(NUM_REQ),
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_bus,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wdata,
  output logic [IDX_W-1:0]         owner,
  output logic                     busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  // First requesting index at or after 'from', wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IDX_W-1:0]   from);
    logic [IDX_W-1:0] p;
    logic [IDX_W:0]   sum;
    p = from;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, from} + (IDX_W+1)'(k);
      sum = (sum >= (IDX_W+1)'(NUM_REQ)) ? sum - (IDX_W+1)'(NUM_REQ) : sum;
      p   = r[sum[IDX_W-1:0]] ? sum[IDX_W-1:0] : p;
    end
    return p;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  logic [0:0]         fsm_q, fsm_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               busy_s;
  logic               req_own_s;
  logic               wr_en_s;
  logic               release_s;
  logic [IDX_W:0]     inc_sum_s;
  logic [IDX_W-1:0]   owner_inc_s;
  logic [IDX_W-1:0]   pick_idle_s;
  logic [IDX_W-1:0]   pick_next_s;
  logic [WIDTH-1:0]   data_mux_s;

  assign busy_s      = (fsm_q == BUSY);
  assign req_own_s   = req[owner_q];
  assign wr_en_s     = busy_s & req_own_s & ~fifo_full;
  assign release_s   = ~req_own_s | (wr_en_s & (cnt_q == CNT_LAST));
  assign pick_idle_s = pick(req, rr_ptr_q);
  assign pick_next_s = pick(req, owner_inc_s);

  // Successor of the current owner, modulo NUM_REQ.
  always_comb begin
    inc_sum_s   = {1'b0, owner_q} + {{IDX_W{1'b0}}, 1'b1};
    owner_inc_s = (inc_sum_s >= (IDX_W+1)'(NUM_REQ)) ? {IDX_W{1'b0}} : inc_sum_s[IDX_W-1:0];
  end

  // Select the owner's data slice.
  always_comb begin
    data_mux_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        data_mux_s = wdata_bus[i*WIDTH +: WIDTH];
      end else begin
        data_mux_s = data_mux_s;
      end
    end
  end

  // Arbitration and burst bookkeeping.
  always_comb begin
    fsm_d    = fsm_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (|req) begin
          fsm_d   = BUSY;
          owner_d = pick_idle_s;
          gnt_d   = onehot(pick_idle_s);
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          fsm_d   = IDLE;
        end
      end
      BUSY: begin
        if (release_s) begin
          rr_ptr_d = owner_inc_s;
          cnt_d    = {CNT_W{1'b0}};
          // A still-requesting owner may be re-granted with no bubble.
          if (|req) begin
            owner_d = pick_next_s;
            gnt_d   = onehot(pick_next_s);
          end else begin
            fsm_d   = IDLE;
            owner_d = {IDX_W{1'b0}};
            gnt_d   = {NUM_REQ{1'b0}};
          end
        end else if (wr_en_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        fsm_d    = IDLE;
        gnt_d    = {NUM_REQ{1'b0}};
        owner_d  = {IDX_W{1'b0}};
        rr_ptr_d = {IDX_W{1'b0}};
        cnt_d    = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= IDLE;
      gnt_q    <= {NUM_REQ{1'b0}};
      owner_q  <= {IDX_W{1'b0}};
      rr_ptr_q <= {IDX_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      fsm_q    <= fsm_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign owner      = owner_q;
  assign busy       = busy_s;
  assign fifo_wr_en = wr_en_s;
  assign ack        = gnt_q & {NUM_REQ{wr_en_s}};
  assign fifo_wdata = busy_s ? data_mux_s : {WIDTH{1'b0}};

endmodule
